// File: rtl/synth_mode_sequencer.sv
// Waveform mode sequencer: debounced keys and a demo auto-step drive a three-value
// mode ring (00 -> 01 -> 11), with every change wrapped in a fade-out/fade-in mute window.
module synth_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MUTE_CYCLES     = 2048,
    parameter int AUTO_CYCLES     = 150_000_000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_next,
    input  logic       key_prev,
    input  logic       sw_auto,
    output logic [1:0] mode,
    output logic       mute,
    output logic       mode_strobe
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MW = $clog2(MUTE_CYCLES + 1);
    localparam int AW = $clog2(AUTO_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [MW-1:0] MUTE_LAST = MW'(MUTE_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_MAX  = AW'(AUTO_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } state_e;

    // Ring step; the illegal code 10 recovers to 00 in either direction.
    function automatic logic [1:0] next_mode(input logic [1:0] cur, input logic fwd);
        logic [1:0] nxt;
        case (cur)
            2'b00:   nxt = fwd ? 2'b01 : 2'b11;
            2'b01:   nxt = fwd ? 2'b11 : 2'b00;
            2'b11:   nxt = fwd ? 2'b00 : 2'b01;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    logic [1:0]         key_meta_q, key_sync_q;
    logic [1:0]         key_deb_q, key_deb_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         press_q, press_d;
    logic               auto_meta_q, auto_sync_q;
    logic [AW-1:0]      auto_cnt_q, auto_cnt_d;

    state_e        state_q, state_d;
    logic [MW-1:0] mute_cnt_q, mute_cnt_d;
    logic          dir_q, dir_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_dir_q, pend_dir_d;
    logic [1:0]    mode_q, mode_d;
    logic          mute_q, mute_d;
    logic          strobe_q, strobe_d;

    logic key_req_s, key_fwd_s, idle_s, tick_s, req_s, req_fwd_s, store_s;

    // Debounce both keys (bit 0 = next, bit 1 = prev); press fires on the accepted 1->0 edge.
    always_comb begin
        key_deb_d = key_deb_q;
        deb_cnt_d = deb_cnt_q;
        press_d   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (key_sync_q[k] != key_deb_q[k]) begin
                if (deb_cnt_q[k] == DEB_LAST) begin
                    key_deb_d[k] = key_sync_q[k];
                    deb_cnt_d[k] = {DW{1'b0}};
                    press_d[k]   = ~key_sync_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
                end
            end else begin
                deb_cnt_d[k] = {DW{1'b0}};
            end
        end
    end

    assign key_req_s = press_q[0] ^ press_q[1];
    assign key_fwd_s = press_q[0];
    assign idle_s    = (state_q == IDLE);
    assign tick_s    = auto_sync_q & idle_s & ~pend_valid_q & ~key_req_s & (auto_cnt_q == AUTO_MAX);
    assign req_s     = key_req_s | tick_s;
    assign req_fwd_s = key_req_s ? key_fwd_s : 1'b1;
    assign store_s   = ~idle_s & req_s & ~pend_valid_q;

    // Demo timer: counts idle cycles with nothing queued, never wraps.
    always_comb begin
        if (!auto_sync_q || key_req_s || !idle_s) begin
            auto_cnt_d = {AW{1'b0}};
        end else if (pend_valid_q) begin
            auto_cnt_d = auto_cnt_q;
        end else if (tick_s) begin
            auto_cnt_d = {AW{1'b0}};
        end else if (auto_cnt_q < AUTO_MAX) begin
            auto_cnt_d = auto_cnt_q + AW'(1);
        end else begin
            auto_cnt_d = auto_cnt_q;
        end
    end

    // Input synchronizers, debouncer state and demo timer.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_meta_q  <= 2'b11;
            key_sync_q  <= 2'b11;
            key_deb_q   <= 2'b11;
            deb_cnt_q   <= {2{{DW{1'b0}}}};
            press_q     <= 2'b00;
            auto_meta_q <= 1'b0;
            auto_sync_q <= 1'b0;
            auto_cnt_q  <= {AW{1'b0}};
        end else begin
            key_meta_q  <= {key_prev, key_next};
            key_sync_q  <= key_meta_q;
            key_deb_q   <= key_deb_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
            auto_meta_q <= sw_auto;
            auto_sync_q <= auto_meta_q;
            auto_cnt_q  <= auto_cnt_d;
        end
    end

    // Next-state logic; a queued request outranks a fresh one arriving in IDLE.
    always_comb begin
        state_d      = state_q;
        mute_cnt_d   = mute_cnt_q;
        dir_d        = dir_q;
        pend_valid_d = pend_valid_q | store_s;
        pend_dir_d   = store_s ? req_fwd_s : pend_dir_q;
        case (state_q)
            IDLE: begin
                mute_cnt_d = {MW{1'b0}};
                if (pend_valid_q) begin
                    state_d      = FADE_OUT;
                    dir_d        = pend_dir_q;
                    pend_valid_d = 1'b0;
                end else if (req_s) begin
                    state_d = FADE_OUT;
                    dir_d   = req_fwd_s;
                end else begin
                    state_d = IDLE;
                end
            end
            FADE_OUT: begin
                if (mute_cnt_q == MUTE_LAST) begin
                    state_d    = SWAP;
                    mute_cnt_d = {MW{1'b0}};
                end else begin
                    mute_cnt_d = mute_cnt_q + MW'(1);
                end
            end
            SWAP: begin
                state_d    = FADE_IN;
                mute_cnt_d = {MW{1'b0}};
            end
            FADE_IN: begin
                if (mute_cnt_q == MUTE_LAST) begin
                    state_d    = IDLE;
                    mute_cnt_d = {MW{1'b0}};
                end else begin
                    mute_cnt_d = mute_cnt_q + MW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                mute_cnt_d = {MW{1'b0}};
            end
        endcase
    end

    // Output logic: mode swaps on the edge leaving SWAP, strobe marks its first visible cycle.
    always_comb begin
        mute_d = (state_d != IDLE);
        if (state_q == SWAP) begin
            mode_d   = next_mode(mode_q, dir_q);
            strobe_d = 1'b1;
        end else begin
            mode_d   = mode_q;
            strobe_d = 1'b0;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            mute_cnt_q   <= {MW{1'b0}};
            dir_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= 1'b0;
            mode_q       <= 2'b00;
            mute_q       <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mute_cnt_q   <= mute_cnt_d;
            dir_q        <= dir_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            mode_q       <= mode_d;
            mute_q       <= mute_d;
            strobe_q     <= strobe_d;
        end
    end

    assign mode        = mode_q;
    assign mute        = mute_q;
    assign mode_strobe = strobe_q;

endmodule

// File: tb/tb_synth_mode_sequencer.sv
// Self-checking bench for synth_mode_sequencer: scenario table, hand-written corner
// sequences and random key/switch activity, all checked against a timestamp-based model.
module tb_synth_mode_sequencer;
    localparam int DEB  = 4;
    localparam int MUTE = 3;
    localparam int AUTO = 20;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       key_next = 1'b1;
    logic       key_prev = 1'b1;
    logic       sw_auto  = 1'b0;
    logic [1:0] mode;
    logic       mute;
    logic       mode_strobe;

    synth_mode_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .MUTE_CYCLES    (MUTE),
        .AUTO_CYCLES    (AUTO)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .key_next   (key_next),
        .key_prev   (key_prev),
        .sw_auto    (sw_auto),
        .mode       (mode),
        .mute       (mute),
        .mode_strobe(mode_strobe)
    );

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: keys seen through a 2-cycle delay, debounced by run length,
    // each accepted change tracked as a set of timestamps.
    bit         n_d1 = 1'b1, n_d2 = 1'b1, p_d1 = 1'b1, p_d2 = 1'b1, s_d1 = 1'b0, s_d2 = 1'b0;
    bit         n_deb = 1'b1, p_deb = 1'b1;
    int         n_run = 0, p_run = 0, auto_run = 0;
    int         m_start = -100, m_end = -1, m_swap = -1;
    logic [1:0] m_mode = 2'b00, m_target = 2'b00;
    bit         m_pend = 1'b0, m_pdir = 1'b0;
    bit         exp_mute = 1'b0, exp_strobe = 1'b0;

    function automatic logic [1:0] ring_step(input logic [1:0] m, input bit fwd);
        logic [1:0] ring [3];
        int pos;
        ring[0] = 2'b00; ring[1] = 2'b01; ring[2] = 2'b11;
        pos = -1;
        for (int i = 0; i < 3; i++) if (ring[i] == m) pos = i;
        if (pos < 0) return 2'b00;
        return fwd ? ring[(pos + 1) % 3] : ring[(pos + 2) % 3];
    endfunction

    task automatic model_reset(input int c);
        n_d1 = 1'b1; n_d2 = 1'b1; p_d1 = 1'b1; p_d2 = 1'b1; s_d1 = 1'b0; s_d2 = 1'b0;
        n_deb = 1'b1; p_deb = 1'b1; n_run = 0; p_run = 0; auto_run = 0;
        m_start = c - 100; m_end = c; m_swap = -1;
        m_mode = 2'b00; m_pend = 1'b0;
        exp_mute = 1'b0; exp_strobe = 1'b0;
    endtask

    task automatic launch(input int c, input bit fwd);
        m_start  = c;
        m_end    = c + 2 * MUTE + 1;
        m_swap   = c + MUTE + 2;
        m_target = ring_step(m_mode, fwd);
    endtask

    task automatic model_step(input int c, input bit kn, input bit kp, input bit sw);
        bit sn, sp, pn, pp, idle, key_req, tick, req, fwd;
        sn = n_d2; n_d2 = n_d1; n_d1 = kn;
        sp = p_d2; p_d2 = p_d1; p_d1 = kp;
        s_d2 = s_d1; s_d1 = sw;
        pn = 1'b0; pp = 1'b0;
        if (sn != n_deb) begin
            n_run++;
            if (n_run == DEB) begin n_deb = sn; n_run = 0; pn = !sn; end
        end else n_run = 0;
        if (sp != p_deb) begin
            p_run++;
            if (p_run == DEB) begin p_deb = sp; p_run = 0; pp = !sp; end
        end else p_run = 0;

        exp_strobe = (c == m_swap);
        if (exp_strobe) m_mode = m_target;
        exp_mute = (c > m_start) && (c <= m_end);
        idle     = (c > m_end);

        key_req = pn ^ pp;
        tick    = s_d2 && idle && !m_pend && !key_req && (auto_run == AUTO);
        if (!s_d2 || key_req || !idle) auto_run = 0;
        else if (m_pend)               auto_run = auto_run;
        else if (tick)                 auto_run = 0;
        else if (auto_run < AUTO)      auto_run++;
        req = key_req || tick;
        fwd = key_req ? pn : 1'b1;
        if (idle) begin
            if (m_pend) begin launch(c, m_pdir); m_pend = 1'b0; end
            else if (req) launch(c, fwd);
        end else if (req && !m_pend) begin
            m_pend = 1'b1; m_pdir = fwd;
        end
    endtask

    // Observations of the DUT gathered each cycle, used by the scenario checks.
    int         strobe_cnt = 0, mute_cnt = 0, last_gap = -1, strobe_gap = -1;
    int         last_strobe_c = -1000, fall_c = -1000;
    bit         prev_rst_ok = 1'b0, prev_mute = 1'b0;
    logic [1:0] prev_mode = 2'b00;

    // One clock: capture inputs at the edge, compare outputs 1 ns later, return at the falling edge.
    task automatic step_cycle();
        bit r, kn, kp, sw;
        @(posedge CLOCK_50);
        r = resetn; kn = key_next; kp = key_prev; sw = sw_auto;
        #1;
        cyc++;
        if (!r) model_reset(cyc);
        else    model_step(cyc, kn, kp, sw);
        chk("mode", int'(mode), int'(m_mode));
        chk("mute", int'(mute), int'(exp_mute));
        chk("strobe", int'(mode_strobe), int'(exp_strobe));
        if (r) begin
            if (prev_rst_ok) chk("strobe_align", int'(mode_strobe), int'(mode != prev_mode));
            if (mode_strobe) begin
                strobe_cnt++;
                strobe_gap    = cyc - last_strobe_c;
                last_strobe_c = cyc;
            end
            if (mute) mute_cnt++;
            if (prev_mute && !mute) fall_c = cyc;
            if (!prev_mute && mute) last_gap = cyc - fall_c;
        end
        prev_rst_ok = r;
        prev_mode   = mode;
        prev_mute   = mute;
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        key_next = 1'b1; key_prev = 1'b1; sw_auto = 1'b0; resetn = 1'b0;
        repeat (3) step_cycle();
        resetn = 1'b1;
        step_cycle();
    endtask

    task automatic press(input bit is_next);
        if (is_next) key_next = 1'b0; else key_prev = 1'b0;
        repeat (8) step_cycle();
        key_next = 1'b1; key_prev = 1'b1;
        repeat (30) step_cycle();
    endtask

    task automatic wait_strobe(input int max_cycles);
        int found;
        found = 0;
        for (int i = 0; i < max_cycles && found == 0; i++) begin
            step_cycle();
            if (mode_strobe) found = 1;
        end
        chk("strobe_wait", found, 1);
    endtask

    typedef struct {
        int         n_next;
        int         n_prev;
        logic [1:0] exp_mode;
        int         exp_strobes;
        int         exp_mute;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int s0, m0, nleft, pleft, sleft;
        vecs[0] = '{n_next: 1, n_prev: 0, exp_mode: 2'b01, exp_strobes: 1, exp_mute: 7};
        vecs[1] = '{n_next: 0, n_prev: 3, exp_mode: 2'b00, exp_strobes: 3, exp_mute: 21};
        vecs[2] = '{n_next: 2, n_prev: 0, exp_mode: 2'b11, exp_strobes: 2, exp_mute: 14};
        vecs[3] = '{n_next: 0, n_prev: 1, exp_mode: 2'b11, exp_strobes: 1, exp_mute: 7};
        vecs[4] = '{n_next: 4, n_prev: 1, exp_mode: 2'b00, exp_strobes: 5, exp_mute: 35};

        do_reset();
        chk("reset_mode", int'(mode), 0);
        chk("reset_mute", int'(mute), 0);
        chk("reset_strobe", int'(mode_strobe), 0);

        // Scenario table: spaced presses from reset.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            s0 = strobe_cnt; m0 = mute_cnt;
            for (int i = 0; i < vecs[v].n_next; i++) press(1'b1);
            for (int i = 0; i < vecs[v].n_prev; i++) press(1'b0);
            chk($sformatf("vec%0d_mode", v), int'(mode), int'(vecs[v].exp_mode));
            chk($sformatf("vec%0d_strobes", v), strobe_cnt - s0, vecs[v].exp_strobes);
            chk($sformatf("vec%0d_mute", v), mute_cnt - m0, vecs[v].exp_mute);
        end

        // Bouncing key: short pulses are ignored, the final hold yields one change.
        do_reset();
        s0 = strobe_cnt; m0 = mute_cnt;
        key_next = 1'b0; repeat (3) step_cycle();
        key_next = 1'b1; repeat (2) step_cycle();
        key_next = 1'b0; repeat (1) step_cycle();
        key_next = 1'b1; repeat (3) step_cycle();
        key_next = 1'b0; repeat (2) step_cycle();
        key_next = 1'b1; repeat (12) step_cycle();
        chk("bounce_no_strobe", strobe_cnt - s0, 0);
        chk("bounce_no_mute", mute_cnt - m0, 0);
        key_next = 1'b0; repeat (10) step_cycle();
        key_next = 1'b1; repeat (20) step_cycle();
        chk("bounce_strobes", strobe_cnt - s0, 1);
        chk("bounce_mode", int'(mode), 1);

        // Auto tick starts a change, a next press queues, a prev press is dropped.
        do_reset();
        s0 = strobe_cnt; m0 = mute_cnt;
        sw_auto = 1'b1;
        repeat (19) step_cycle();
        key_next = 1'b0;
        repeat (2) step_cycle();
        key_prev = 1'b0;
        repeat (3) step_cycle();
        sw_auto = 1'b0;
        repeat (5) step_cycle();
        key_next = 1'b1; key_prev = 1'b1;
        repeat (40) step_cycle();
        chk("pend_strobes", strobe_cnt - s0, 2);
        chk("pend_mute", mute_cnt - m0, 14);
        chk("pend_gap", last_gap, 1);
        chk("pend_mode", int'(mode), 3);

        // Demo stepping period, restart by a key press, and stop.
        do_reset();
        sw_auto = 1'b1;
        wait_strobe(60);
        wait_strobe(60);
        chk("auto_period1", strobe_gap, AUTO + 2 * MUTE + 2);
        wait_strobe(60);
        chk("auto_period2", strobe_gap, AUTO + 2 * MUTE + 2);
        repeat (5) step_cycle();
        key_next = 1'b0;
        wait_strobe(30);
        key_next = 1'b1;
        wait_strobe(60);
        chk("auto_after_key", strobe_gap, AUTO + 2 * MUTE + 2);
        sw_auto = 1'b0;
        s0 = strobe_cnt;
        repeat (80) step_cycle();
        chk("auto_off", strobe_cnt - s0, 0);

        // Reset asserted during the fade-in phase.
        do_reset();
        key_next = 1'b0;
        wait_strobe(40);
        key_next = 1'b1;
        step_cycle();
        chk("pre_reset_mute", int'(mute), 1);
        resetn = 1'b0;
        #1;
        chk("midreset_mode", int'(mode), 0);
        chk("midreset_mute", int'(mute), 0);
        chk("midreset_strobe", int'(mode_strobe), 0);
        s0 = strobe_cnt;
        repeat (3) step_cycle();
        resetn = 1'b1;
        repeat (20) step_cycle();
        chk("postreset_no_strobe", strobe_cnt - s0, 0);
        press(1'b1);
        chk("postreset_mode", int'(mode), 1);

        // Random key and switch activity against the model.
        do_reset();
        nleft = 0; pleft = 0; sleft = 0;
        for (int i = 0; i < 3000; i++) begin
            if (nleft == 0) begin key_next = ~key_next; nleft = $urandom_range(1, 14); end
            else nleft--;
            if (pleft == 0) begin key_prev = ~key_prev; pleft = $urandom_range(1, 14); end
            else pleft--;
            if (sleft == 0) begin sw_auto = ~sw_auto; sleft = $urandom_range(40, 300); end
            else sleft--;
            step_cycle();
        end
        key_next = 1'b1; key_prev = 1'b1; sw_auto = 1'b0;
        repeat (40) step_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
